alu_mdu: RTL and testbench
==========================

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values 8..64, even.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  request accepted when in_valid&in_ready.
REQ-006 SHALL have ports A, B  input  WIDTH  operands.
REQ-007 SHALL have port ALUFun  input  6  operation code.
REQ-008 SHALL have port Sign  input  1  1=signed compare/overflow/mul/div.
REQ-009 SHALL have port out_valid  output  1  result held on Z until out_ready.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port Z  output  WIDTH  result.
REQ-012 SHALL have port V  output  1  add/sub overflow (signed, or unsigned carry/borrow when Sign=0).
REQ-013 SHALL have port err  output  1  divide-by-zero or illegal ALUFun.

Function
REQ-014 Single-cycle ops SHALL be: 000000 ADD, 000001 SUB, 011000 AND, 011110 OR, 010110 XOR, 010001 NOR, 011010 pass A, 100000 SLL, 100001 SRL, 100011 SRA, 110011 EQ, 110001 NEQ, 110101 LT, 111101 LEZ, 111011 LTZ, 111111 GTZ.
REQ-015 Shifts SHALL shift B by A[log2(WIDTH)-1:0]; compares SHALL return 1 or 0 zero-extended; LEZ/LTZ/GTZ test A only, signed always.
REQ-016 Single-cycle ops SHALL set out_valid on the cycle after acceptance (latency 1).
REQ-017 Multi-cycle ops SHALL be: 001000 MUL, 001001 DIV, writing internal registers HI and LO (WIDTH each); 001010 MFHI and 001011 MFLO SHALL be single-cycle reads.
REQ-018 MUL SHALL be radix-2 iterative: {HI,LO}=A*B, signed per Sign; DIV SHALL be restoring: LO=quotient, HI=remainder, remainder sign follows A when signed.
REQ-019 FSM SHALL have states IDLE, BUSY, DONE: IDLE->BUSY on accepted MUL/DIV; BUSY counts WIDTH cycles then ->DONE; DONE->IDLE when out_ready.
REQ-020 MUL/DIV SHALL assert out_valid exactly WIDTH+1 cycles after acceptance, Z=LO.
REQ-021 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready); back-to-back ops SHALL sustain one per cycle when out_ready=1.
REQ-022 Z, V, err SHALL remain stable while out_valid && !out_ready.
REQ-023 DIV with B=0 SHALL complete in 1 cycle: HI=A, LO=all ones, err=1.
REQ-024 Signed DIV of most-negative by -1 SHALL give LO=most-negative, HI=0, err=0.
REQ-025 Illegal ALUFun SHALL give Z=0, err=1, latency 1, HI/LO unchanged.
REQ-026 V and err SHALL be 0 for every op not defining them.

Reset
REQ-027 Asserting rst_n low SHALL immediately force state=IDLE, out_valid=0, Z=0, V=0, err=0, HI=0, LO=0, counter=0, in_ready=0 while low.
REQ-028 Reset during BUSY SHALL abort the operation with no result delivered; in_ready=1 first rising edge after release.

Configuration
REQ-029 Macro ALU_MDU_DIV_EN defined SHALL include the divider and DIV op.
REQ-030 Without ALU_MDU_DIV_EN, DIV SHALL be treated as illegal (REQ-025) and no divider logic SHALL be synthesised; MUL unaffected.

Verification
REQ-031 WIDTH=32, A=5, B=0, Sign=1, each REQ-014 op, out_ready=1 -> ADD 5, SUB 5, AND 0, OR 5, XOR 5, NOR FFFFFFFA, passA 5, SLL/SRL/SRA 0, EQ 0, NEQ 1, LT 0, LEZ 0, LTZ 0, GTZ 1, each 1 cycle later.
REQ-032 ADD 7FFFFFFF+1 Sign=1 -> Z=80000000, V=1; same with Sign=0 -> V=0.
REQ-033 MUL A=FFFFFFFE, B=3, Sign=1 -> out_valid at cycle 33, Z=FFFFFFFA; MFHI -> FFFFFFFF; in_ready=0 during cycles 1..32.
REQ-034 DIV A=-7, B=2, Sign=1 (DIV_EN) -> LO=FFFFFFFD, HI=FFFFFFFF; DIV B=0 -> 1 cycle, LO=FFFFFFFF, HI=A, err=1; without DIV_EN -> Z=0, err=1.
REQ-035 out_ready=0 for 5 cycles after result -> Z/V/err stable, in_ready=0; then out_ready=1 -> next op accepted same cycle.
REQ-036 rst_n low at cycle 10 of MUL -> out_valid never rises for it, HI=LO=0, next op accepted normally.

Source files
------------

// File: rtl/alu_mdu.sv
// alu_mdu: single-cycle ALU plus iterative MUL/DIV with HI/LO (divider only with ALU_MDU_DIV_EN); in: in_valid A B ALUFun Sign out_ready, out: in_ready out_valid Z V err
module alu_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       ALUFun,
  input  logic             Sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             V,
  output logic             err
);
  localparam int SW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] hi, lo, acc, mq, dvs, a_mag, b_mag, r_z, acc_n, mq_n, fin_hi, fin_lo;
  logic [WIDTH:0] sum, dif, msum;
  logic [2*WIDTH-1:0] prod;
  logic [SW-1:0] sh, cnt;
  logic fire, is_mul, div_go, div_zero, neg_q, r_v, r_err, lt;
  assign in_ready = rst_n && state == IDLE && (!out_valid || out_ready);
  assign fire = in_valid && in_ready;
  assign sh = A[SW-1:0];
  assign sum = {1'b0, A} + {1'b0, B};
  assign dif = {1'b0, A} - {1'b0, B};
  assign lt = Sign ? $signed(A) < $signed(B) : A < B;
  assign is_mul = ALUFun == 6'b001000;
  assign a_mag = Sign && A[WIDTH-1] ? -A : A;
  assign b_mag = Sign && B[WIDTH-1] ? -B : B;
  assign msum = {1'b0, acc} + (mq[0] ? {1'b0, dvs} : '0);
  assign prod = neg_q ? -{acc_n, mq_n} : {acc_n, mq_n};
`ifdef ALU_MDU_DIV_EN
  logic is_div, neg_r;
  logic [WIDTH:0] shd, ddif;
  assign div_go = ALUFun == 6'b001001 && B != '0;
  assign div_zero = ALUFun == 6'b001001 && B == '0;
  assign shd = {acc, mq[WIDTH-1]};
  assign ddif = shd - {1'b0, dvs};
  assign acc_n = !is_div ? msum[WIDTH:1] : ddif[WIDTH] ? shd[WIDTH-1:0] : ddif[WIDTH-1:0];
  assign mq_n = is_div ? {mq[WIDTH-2:0], !ddif[WIDTH]} : {msum[0], mq[WIDTH-1:1]};
  assign fin_hi = !is_div ? prod[2*WIDTH-1:WIDTH] : neg_r ? -acc_n : acc_n;
  assign fin_lo = !is_div ? prod[WIDTH-1:0] : neg_q ? -mq_n : mq_n;
`else
  assign div_go = 1'b0;
  assign div_zero = 1'b0;
  assign acc_n = msum[WIDTH:1];
  assign mq_n = {msum[0], mq[WIDTH-1:1]};
  assign fin_hi = prod[2*WIDTH-1:WIDTH];
  assign fin_lo = prod[WIDTH-1:0];
`endif
  always_comb begin
    r_z = '0;
    r_v = 1'b0;
    r_err = 1'b0;
    case (ALUFun)
      6'b000000: begin r_z = sum[WIDTH-1:0]; r_v = Sign ? A[WIDTH-1] == B[WIDTH-1] && sum[WIDTH-1] != A[WIDTH-1] : sum[WIDTH]; end
      6'b000001: begin r_z = dif[WIDTH-1:0]; r_v = Sign ? A[WIDTH-1] != B[WIDTH-1] && dif[WIDTH-1] != A[WIDTH-1] : dif[WIDTH]; end
      6'b011000: r_z = A & B;
      6'b011110: r_z = A | B;
      6'b010110: r_z = A ^ B;
      6'b010001: r_z = ~(A | B);
      6'b011010: r_z = A;
      6'b100000: r_z = B << sh;
      6'b100001: r_z = B >> sh;
      6'b100011: r_z = $signed(B) >>> sh;
      6'b110011: r_z = WIDTH'(A == B);
      6'b110001: r_z = WIDTH'(A != B);
      6'b110101: r_z = WIDTH'(lt);
      6'b111101: r_z = WIDTH'(A[WIDTH-1] || A == '0);
      6'b111011: r_z = WIDTH'(A[WIDTH-1]);
      6'b111111: r_z = WIDTH'(!A[WIDTH-1] && A != '0);
      6'b001000: r_err = 1'b0;
      6'b001010: r_z = hi;
      6'b001011: r_z = lo;
`ifdef ALU_MDU_DIV_EN
      6'b001001: begin r_z = '1; r_err = 1'b1; end
`endif
      default: r_err = 1'b1;
    endcase
  end
  // operands are iterated as magnitudes; sign is restored on the final step
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      out_valid <= 1'b0;
      Z <= '0;
      V <= 1'b0;
      err <= 1'b0;
      hi <= '0;
      lo <= '0;
      acc <= '0;
      mq <= '0;
      dvs <= '0;
      cnt <= '0;
      neg_q <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      is_div <= 1'b0;
      neg_r <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        IDLE: if (fire) begin
          if (is_mul || div_go) begin
            state <= BUSY;
            acc <= '0;
            mq <= a_mag;
            dvs <= b_mag;
            cnt <= '0;
            neg_q <= Sign && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef ALU_MDU_DIV_EN
            is_div <= div_go;
            neg_r <= Sign && A[WIDTH-1];
`endif
          end else begin
            out_valid <= 1'b1;
            Z <= r_z;
            V <= r_v;
            err <= r_err;
            if (div_zero) begin
              hi <= A;
              lo <= '1;
            end
          end
        end
        BUSY: begin
          acc <= acc_n;
          mq <= mq_n;
          cnt <= cnt + 1'b1;
          if (cnt == SW'(WIDTH - 1)) begin
            state <= DONE;
            out_valid <= 1'b1;
            Z <= fin_lo;
            V <= 1'b0;
            err <= 1'b0;
            hi <= fin_hi;
            lo <= fin_lo;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: directed self-checking bench for alu_mdu at WIDTH=32
module tb_alu_mdu;
  localparam int W = 32;
  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, AND_ = 6'b011000, OR_ = 6'b011110,
    XOR_ = 6'b010110, NOR_ = 6'b010001, PASSA = 6'b011010, SLL = 6'b100000, SRL = 6'b100001,
    SRA = 6'b100011, EQ = 6'b110011, NEQ = 6'b110001, LT = 6'b110101, LEZ = 6'b111101,
    LTZ = 6'b111011, GTZ = 6'b111111, MUL = 6'b001000, DIV = 6'b001001, MFHI = 6'b001010,
    MFLO = 6'b001011;
  logic clk = 0, rst_n = 1, in_valid = 0, Sign = 0, out_ready = 1;
  logic in_ready, out_valid, V, err;
  logic [W-1:0] A = '0, B = '0, Z;
  logic [5:0] ALUFun = '0;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  alu_mdu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .ALUFun(ALUFun), .Sign(Sign), .out_valid(out_valid), .out_ready(out_ready),
    .Z(Z), .V(V), .err(err));
  task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    in_valid = 1; ALUFun = f; A = a; B = b; Sign = s;
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic wait_done(output int lat, output bit rdy);
    lat = 1; rdy = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      rdy |= (in_ready === 1'b1);
      @(negedge clk);
      lat++;
    end
  endtask
  task automatic test_reset;
    #2 rst_n = 0; in_valid = 1; ALUFun = ADD; A = 5;
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0 || Z !== '0 || V !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_state: out_valid=%b Z=%h V=%b err=%b in_ready=%b, want all 0", out_valid, Z, V, err, in_ready); end
    in_valid = 0;
    @(negedge clk); rst_n = 1; #1;
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    @(negedge clk);
    n_chk++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_no_result: out_valid=%b want 0", out_valid); end
  endtask
  task automatic test_alu_ops;
    logic [5:0] ops [16] = '{ADD, SUB, AND_, OR_, XOR_, NOR_, PASSA, SLL, SRL, SRA, EQ, NEQ, LT, LEZ, LTZ, GTZ};
    logic [W-1:0] ez [16] = '{5, 5, 0, 5, 5, 32'hFFFFFFFA, 5, 0, 0, 0, 0, 1, 0, 0, 0, 1};
    for (int i = 0; i < 16; i++) begin
      issue(ops[i], 5, 0, 1);
      n_chk++; if (out_valid !== 1'b1 || Z !== ez[i] || V !== 1'b0 || err !== 1'b0) begin
        n_err++; $display("FAIL alu_op[%0d]: out_valid=%b Z=%h V=%b err=%b, want 1 %h 0 0", i, out_valid, Z, V, err, ez[i]); end
    end
  endtask
  task automatic test_edges;
    logic [5:0] ops [14] = '{ADD, ADD, ADD, SUB, SUB, LT, LT, SRA, SLL, SRL, LEZ, LTZ, GTZ, EQ};
    logic [W-1:0] ea [14] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 0, 32'h80000000, 32'hFFFFFFFF,
      32'hFFFFFFFF, 4, 33, 31, 0, 32'h80000000, 32'h80000000, 9};
    logic [W-1:0] eb [14] = '{1, 1, 1, 1, 1, 1, 1, 32'h80000000, 1, 32'h80000000, 0, 0, 0, 9};
    logic es [14] = '{1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    logic [W-1:0] ez [14] = '{32'h80000000, 32'h80000000, 0, 32'hFFFFFFFF, 32'h7FFFFFFF, 1, 0,
      32'hF8000000, 2, 1, 1, 1, 0, 1};
    logic ev [14] = '{1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      issue(ops[i], ea[i], eb[i], es[i]);
      n_chk++; if (out_valid !== 1'b1 || Z !== ez[i] || V !== ev[i] || err !== 1'b0) begin
        n_err++; $display("FAIL edge[%0d]: out_valid=%b Z=%h V=%b err=%b, want 1 %h %b 0", i, out_valid, Z, V, err, ez[i], ev[i]); end
    end
  endtask
  task automatic test_mul;
    int lat; bit rdy;
    issue(MUL, 32'hFFFFFFFE, 3, 1);
    wait_done(lat, rdy);
    n_chk++; if (lat != 33) begin n_err++; $display("FAIL mul_latency: got %0d want 33", lat); end
    n_chk++; if (rdy) begin n_err++; $display("FAIL mul_busy_ready: in_ready seen 1 while busy, want 0"); end
    n_chk++; if (Z !== 32'hFFFFFFFA || V !== 1'b0 || err !== 1'b0) begin
      n_err++; $display("FAIL mul_lo: Z=%h V=%b err=%b want FFFFFFFA 0 0", Z, V, err); end
    @(negedge clk);
    issue(MFHI, 0, 0, 0);
    n_chk++; if (Z !== 32'hFFFFFFFF || err !== 1'b0) begin n_err++; $display("FAIL mul_hi: Z=%h err=%b want FFFFFFFF 0", Z, err); end
    issue(MFLO, 0, 0, 0);
    n_chk++; if (Z !== 32'hFFFFFFFA) begin n_err++; $display("FAIL mul_mflo: Z=%h want FFFFFFFA", Z); end
    issue(MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    wait_done(lat, rdy);
    n_chk++; if (lat != 33 || Z !== 32'h00000001) begin n_err++; $display("FAIL mul_unsigned: lat=%0d Z=%h want 33 00000001", lat, Z); end
    @(negedge clk);
    issue(MFHI, 0, 0, 0);
    n_chk++; if (Z !== 32'hFFFFFFFE) begin n_err++; $display("FAIL mul_unsigned_hi: Z=%h want FFFFFFFE", Z); end
  endtask
`ifdef ALU_MDU_DIV_EN
  task automatic test_div;
    int lat; bit rdy;
    issue(DIV, 32'hFFFFFFF9, 2, 1);
    wait_done(lat, rdy);
    n_chk++; if (lat != 33 || Z !== 32'hFFFFFFFD || err !== 1'b0) begin
      n_err++; $display("FAIL div_signed: lat=%0d Z=%h err=%b want 33 FFFFFFFD 0", lat, Z, err); end
    @(negedge clk);
    issue(MFHI, 0, 0, 0);
    n_chk++; if (Z !== 32'hFFFFFFFF) begin n_err++; $display("FAIL div_rem: Z=%h want FFFFFFFF", Z); end
    issue(DIV, 32'h80000000, 32'hFFFFFFFF, 1);
    wait_done(lat, rdy);
    n_chk++; if (Z !== 32'h80000000 || err !== 1'b0) begin n_err++; $display("FAIL div_minneg: Z=%h err=%b want 80000000 0", Z, err); end
    @(negedge clk);
    issue(MFHI, 0, 0, 0);
    n_chk++; if (Z !== 32'h0) begin n_err++; $display("FAIL div_minneg_rem: Z=%h want 0", Z); end
    issue(DIV, 100, 7, 0);
    wait_done(lat, rdy);
    n_chk++; if (Z !== 32'd14) begin n_err++; $display("FAIL div_unsigned: Z=%h want 0000000e", Z); end
    @(negedge clk);
    issue(MFHI, 0, 0, 0);
    n_chk++; if (Z !== 32'd2) begin n_err++; $display("FAIL div_unsigned_rem: Z=%h want 2", Z); end
    issue(DIV, 32'h1234, 0, 1);
    wait_done(lat, rdy);
    n_chk++; if (lat != 1 || Z !== 32'hFFFFFFFF || err !== 1'b1) begin
      n_err++; $display("FAIL div_zero: lat=%0d Z=%h err=%b want 1 FFFFFFFF 1", lat, Z, err); end
    issue(MFHI, 0, 0, 0);
    n_chk++; if (Z !== 32'h1234 || err !== 1'b0) begin n_err++; $display("FAIL div_zero_hi: Z=%h err=%b want 1234 0", Z, err); end
  endtask
  localparam logic [W-1:0] HI_EXP = 32'h1234, LO_EXP = 32'hFFFFFFFF;
`else
  task automatic test_div;
    int lat; bit rdy;
    issue(DIV, 32'hFFFFFFF9, 2, 1);
    wait_done(lat, rdy);
    n_chk++; if (lat != 1 || Z !== '0 || err !== 1'b1) begin
      n_err++; $display("FAIL div_disabled: lat=%0d Z=%h err=%b want 1 0 1", lat, Z, err); end
  endtask
  localparam logic [W-1:0] HI_EXP = 32'hFFFFFFFE, LO_EXP = 32'h00000001;
`endif
  task automatic test_illegal;
    issue(6'b111110, 1, 2, 0);
    n_chk++; if (out_valid !== 1'b1 || Z !== '0 || err !== 1'b1 || V !== 1'b0) begin
      n_err++; $display("FAIL illegal: out_valid=%b Z=%h err=%b V=%b want 1 0 1 0", out_valid, Z, err, V); end
    issue(MFLO, 0, 0, 0);
    n_chk++; if (Z !== LO_EXP || err !== 1'b0) begin n_err++; $display("FAIL illegal_lo_kept: Z=%h err=%b want %h 0", Z, err, LO_EXP); end
    issue(MFHI, 0, 0, 0);
    n_chk++; if (Z !== HI_EXP) begin n_err++; $display("FAIL illegal_hi_kept: Z=%h want %h", Z, HI_EXP); end
  endtask
  task automatic test_backpressure;
    @(negedge clk);
    out_ready = 0;
    issue(ADD, 32'h7FFFFFFF, 1, 1);
    in_valid = 1; ALUFun = XOR_; A = 32'hF0; B = 32'h0F; Sign = 0;
    for (int i = 0; i < 5; i++) begin
      n_chk++; if (out_valid !== 1'b1 || Z !== 32'h80000000 || V !== 1'b1 || err !== 1'b0 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL hold[%0d]: out_valid=%b Z=%h V=%b err=%b in_ready=%b want 1 80000000 1 0 0", i, out_valid, Z, V, err, in_ready); end
      @(negedge clk);
    end
    out_ready = 1; #1;
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL hold_release_ready: got %b want 1", in_ready); end
    @(negedge clk);
    in_valid = 0;
    n_chk++; if (out_valid !== 1'b1 || Z !== 32'hFF || V !== 1'b0) begin
      n_err++; $display("FAIL hold_next_op: out_valid=%b Z=%h V=%b want 1 000000ff 0", out_valid, Z, V); end
  endtask
  task automatic test_reset_busy;
    int lat; bit rdy, seen;
    issue(MUL, 3, 4, 0);
    repeat (9) @(negedge clk);
    rst_n = 0; #1;
    n_chk++; if (out_valid !== 1'b0 || Z !== '0 || V !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL busy_reset_state: out_valid=%b Z=%h V=%b err=%b in_ready=%b want all 0", out_valid, Z, V, err, in_ready); end
    @(negedge clk); rst_n = 1; #1;
    n_chk++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL busy_reset_ready: got %b want 1", in_ready); end
    seen = 0;
    repeat (40) begin @(negedge clk); seen |= (out_valid !== 1'b0); end
    n_chk++; if (seen) begin n_err++; $display("FAIL busy_reset_abort: out_valid rose after abort, want never"); end
    issue(MFHI, 0, 0, 0);
    n_chk++; if (out_valid !== 1'b1 || Z !== '0) begin n_err++; $display("FAIL busy_reset_hi: out_valid=%b Z=%h want 1 0", out_valid, Z); end
    issue(MFLO, 0, 0, 0);
    n_chk++; if (Z !== '0) begin n_err++; $display("FAIL busy_reset_lo: Z=%h want 0", Z); end
    issue(MUL, 3, 4, 0);
    wait_done(lat, rdy);
    n_chk++; if (lat != 33 || Z !== 32'd12) begin n_err++; $display("FAIL busy_reset_next: lat=%0d Z=%h want 33 0000000c", lat, Z); end
  endtask
  initial begin
    test_reset();
    test_alu_ops();
    test_edges();
    test_mul();
    @(negedge clk);
    test_div();
    @(negedge clk);
    test_illegal();
    test_backpressure();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
